// File: rtl/arp_resolver.sv
// Resolves a destination IPv4 address to a MAC through a 1-entry cache and the ARP table.
// Failed lookups trigger an ARP request and retry after a fixed back-off.
module arp_resolver #(
  parameter int RETRY_MAX   = 3,
  parameter int WAIT_CYCLES = 200000
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [31:0] dst_ip_in,
  input  logic        dst_req_valid_in,
  output logic        dst_req_ready_out,
  output logic [47:0] dst_mac_out,
  output logic        dst_err_out,
  output logic        dst_mac_valid_out,
  input  logic        dst_mac_ready_in,
  input  logic        cache_flush_in,
  output logic [31:0] arp_query_ip_out,
  output logic        arp_query_valid_out,
  input  logic        arp_query_ready_in,
  input  logic [47:0] arp_response_mac_in,
  input  logic        arp_response_valid_in,
  output logic        arp_response_ready_out,
  input  logic        arp_response_err_in,
  output logic [31:0] trig_arp_ip_out,
  output logic        trig_arp_qvalid_out,
  input  logic        trig_arp_qready_in
);

  localparam int TW = $clog2(WAIT_CYCLES + 1);
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(WAIT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);

  typedef enum logic [2:0] {
    IDLE,
    QUERY,
    WAIT_RESP,
    TRIG,
    BACKOFF,
    DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [31:0]   ip_q;
  logic [47:0]   mac_q;
  logic          err_q;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] timer;
  logic          cache_valid;
  logic [31:0]   cache_ip;
  logic [47:0]   cache_mac;

  logic cache_hit;
  logic timer_done;
  logic resp_ok;
  logic resp_fail;
  logic retries_spent;

  assign cache_hit     = cache_valid && (cache_ip == dst_ip_in) && !cache_flush_in;
  assign timer_done    = (timer == TIMER_LAST);
  // A response arriving on the timeout cycle takes priority over the timeout.
  assign resp_ok       = arp_response_valid_in && !arp_response_err_in;
  assign resp_fail     = arp_response_valid_in ? arp_response_err_in : timer_done;
  assign retries_spent = (retry_cnt == RETRY_LAST);

  always_comb begin
    state_d                = state_q;
    dst_req_ready_out      = 1'b0;
    dst_mac_valid_out      = 1'b0;
    dst_mac_out            = '0;
    dst_err_out            = 1'b0;
    arp_query_valid_out    = 1'b0;
    arp_query_ip_out       = '0;
    arp_response_ready_out = 1'b0;
    trig_arp_qvalid_out    = 1'b0;
    trig_arp_ip_out        = '0;
    case (state_q)
      IDLE: begin
        // Held low during reset so every output reads zero while reset is asserted.
        dst_req_ready_out = !logic_rst;
        if (dst_req_valid_in) state_d = cache_hit ? DONE : QUERY;
      end
      QUERY: begin
        arp_query_valid_out = 1'b1;
        arp_query_ip_out    = ip_q;
        if (arp_query_ready_in) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        arp_response_ready_out = 1'b1;
        if (resp_ok)        state_d = DONE;
        else if (resp_fail) state_d = retries_spent ? DONE : TRIG;
      end
      TRIG: begin
        trig_arp_qvalid_out = 1'b1;
        trig_arp_ip_out     = ip_q;
        if (trig_arp_qready_in) state_d = BACKOFF;
      end
      BACKOFF: begin
        if (timer_done) state_d = QUERY;
      end
      DONE: begin
        dst_mac_valid_out = 1'b1;
        dst_mac_out       = mac_q;
        dst_err_out       = err_q;
        if (dst_mac_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state_q     <= IDLE;
      retry_cnt   <= '0;
      timer       <= '0;
      cache_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (dst_req_valid_in) begin
            ip_q      <= dst_ip_in;
            retry_cnt <= '0;
            mac_q     <= cache_mac;
            err_q     <= 1'b0;
          end
        end
        QUERY: begin
          if (arp_query_ready_in) timer <= '0;
        end
        WAIT_RESP: begin
          timer <= timer + TW'(1);
          if (resp_ok) begin
            mac_q       <= arp_response_mac_in;
            err_q       <= 1'b0;
            cache_ip    <= ip_q;
            cache_mac   <= arp_response_mac_in;
            cache_valid <= 1'b1;
          end else if (resp_fail && retries_spent) begin
            mac_q <= '0;
            err_q <= 1'b1;
          end
        end
        TRIG: begin
          if (trig_arp_qready_in) begin
            retry_cnt <= retry_cnt + RW'(1);
            timer     <= '0;
          end
        end
        BACKOFF: begin
          timer <= timer + TW'(1);
        end
        default: ;
      endcase
      // A flush overrides a same-cycle cache load.
      if (cache_flush_in) cache_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arp_resolver.sv
// Directed bench for arp_resolver: a scoreboard queue holds the expected {err, mac}
// for each request, popped when the resolver presents its result.
module tb_arp_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dst_ip_in;
  logic        dst_req_valid_in;
  logic        dst_req_ready_out;
  logic [47:0] dst_mac_out;
  logic        dst_err_out;
  logic        dst_mac_valid_out;
  logic        dst_mac_ready_in;
  logic        cache_flush_in;
  logic [31:0] arp_query_ip_out;
  logic        arp_query_valid_out;
  logic        arp_query_ready_in;
  logic [47:0] arp_response_mac_in;
  logic        arp_response_valid_in;
  logic        arp_response_ready_out;
  logic        arp_response_err_in;
  logic [31:0] trig_arp_ip_out;
  logic        trig_arp_qvalid_out;
  logic        trig_arp_qready_in;

  int checks = 0;
  int errors = 0;
  int n_query = 0;
  int n_trig = 0;
  logic [48:0] sb[$];

  arp_resolver #(.RETRY_MAX(3), .WAIT_CYCLES(16)) dut (
    .logic_clk              (clk),
    .logic_rst              (rst),
    .dst_ip_in              (dst_ip_in),
    .dst_req_valid_in       (dst_req_valid_in),
    .dst_req_ready_out      (dst_req_ready_out),
    .dst_mac_out            (dst_mac_out),
    .dst_err_out            (dst_err_out),
    .dst_mac_valid_out      (dst_mac_valid_out),
    .dst_mac_ready_in       (dst_mac_ready_in),
    .cache_flush_in         (cache_flush_in),
    .arp_query_ip_out       (arp_query_ip_out),
    .arp_query_valid_out    (arp_query_valid_out),
    .arp_query_ready_in     (arp_query_ready_in),
    .arp_response_mac_in    (arp_response_mac_in),
    .arp_response_valid_in  (arp_response_valid_in),
    .arp_response_ready_out (arp_response_ready_out),
    .arp_response_err_in    (arp_response_err_in),
    .trig_arp_ip_out        (trig_arp_ip_out),
    .trig_arp_qvalid_out    (trig_arp_qvalid_out),
    .trig_arp_qready_in     (trig_arp_qready_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arp_query_valid_out && arp_query_ready_in) n_query <= n_query + 1;
    if (trig_arp_qvalid_out && trig_arp_qready_in) n_trig <= n_trig + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] ip, input logic flush);
    int n = 0;
    while (!dst_req_ready_out && n < 100) begin @(negedge clk); n++; end
    check("req_ready", 64'(dst_req_ready_out), 64'd1);
    dst_ip_in        = ip;
    dst_req_valid_in = 1'b1;
    cache_flush_in   = flush;
    @(negedge clk);
    dst_req_valid_in = 1'b0;
    cache_flush_in   = 1'b0;
  endtask

  task automatic query_hs(input logic [31:0] ip);
    int n = 0;
    while (!arp_query_valid_out && n < 100) begin @(negedge clk); n++; end
    check("query_valid", 64'(arp_query_valid_out), 64'd1);
    check("query_ip", 64'(arp_query_ip_out), 64'(ip));
    arp_query_ready_in = 1'b1;
    @(negedge clk);
    arp_query_ready_in = 1'b0;
  endtask

  task automatic respond(input logic [47:0] mac, input logic err, input logic flush);
    check("resp_ready", 64'(arp_response_ready_out), 64'd1);
    arp_response_mac_in   = mac;
    arp_response_err_in   = err;
    arp_response_valid_in = 1'b1;
    cache_flush_in        = flush;
    @(negedge clk);
    arp_response_valid_in = 1'b0;
    arp_response_err_in   = 1'b0;
    cache_flush_in        = 1'b0;
  endtask

  task automatic trig_hs(input logic [31:0] ip);
    int n = 0;
    while (!trig_arp_qvalid_out && n < 100) begin @(negedge clk); n++; end
    check("trig_valid", 64'(trig_arp_qvalid_out), 64'd1);
    check("trig_ip", 64'(trig_arp_ip_out), 64'(ip));
    trig_arp_qready_in = 1'b1;
    @(negedge clk);
    trig_arp_qready_in = 1'b0;
  endtask

  task automatic result(input string tag);
    int n = 0;
    logic [48:0] exp;
    while (!dst_mac_valid_out && n < 100) begin @(negedge clk); n++; end
    check({tag, "_valid"}, 64'(dst_mac_valid_out), 64'd1);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb observed empty scoreboard expected an entry", tag);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    check({tag, "_res"}, 64'({dst_err_out, dst_mac_out}), 64'(exp));
    @(negedge clk);
    check({tag, "_hold"}, 64'({dst_mac_valid_out, dst_err_out, dst_mac_out}), 64'({1'b1, exp}));
    dst_mac_ready_in = 1'b1;
    @(negedge clk);
    dst_mac_ready_in = 1'b0;
    check({tag, "_drop"}, 64'({dst_mac_valid_out, dst_req_ready_out}), 64'b01);
  endtask

  initial begin
    int q0, t0, cnt;
    rst = 1'b1;
    dst_ip_in = '0; dst_req_valid_in = 0; dst_mac_ready_in = 0; cache_flush_in = 0;
    arp_query_ready_in = 0; arp_response_mac_in = '0; arp_response_valid_in = 0;
    arp_response_err_in = 0; trig_arp_qready_in = 0;
    repeat (2) @(negedge clk);
    check("rst_ctl", 64'({dst_req_ready_out, dst_err_out, dst_mac_valid_out, arp_query_valid_out,
                          arp_response_ready_out, trig_arp_qvalid_out}), 64'd0);
    check("rst_mac", 64'(dst_mac_out), 64'd0);
    check("rst_ip", 64'({arp_query_ip_out, trig_arp_ip_out}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(dst_req_ready_out), 64'd1);

    // Cold lookup that populates the cache.
    q0 = n_query;
    sb.push_back({1'b0, 48'h0011_2233_4455});
    do_req(32'hC0A8_0001, 1'b0);
    query_hs(32'hC0A8_0001);
    respond(48'h0011_2233_4455, 1'b0, 1'b0);
    result("cold");
    check("cold_queries", 64'(n_query - q0), 64'd1);

    // Cache hit: result visible one cycle after the handshake, no lookup.
    q0 = n_query;
    sb.push_back({1'b0, 48'h0011_2233_4455});
    do_req(32'hC0A8_0001, 1'b0);
    check("hit_latency", 64'({dst_mac_valid_out, arp_query_valid_out}), 64'b10);
    result("hit");
    check("hit_queries", 64'(n_query - q0), 64'd0);

    // Miss, one trigger, 16-cycle back-off, then learned.
    t0 = n_trig;
    sb.push_back({1'b0, 48'hA1B2_C3D4_E5F6});
    do_req(32'hC0A8_0002, 1'b0);
    query_hs(32'hC0A8_0002);
    respond(48'h0, 1'b1, 1'b0);
    trig_hs(32'hC0A8_0002);
    cnt = 0;
    while (!arp_query_valid_out && cnt < 100) begin @(negedge clk); cnt++; end
    check("backoff_len", 64'(cnt), 64'd16);
    query_hs(32'hC0A8_0002);
    respond(48'hA1B2_C3D4_E5F6, 1'b0, 1'b0);
    result("learn");
    check("learn_trigs", 64'(n_trig - t0), 64'd1);

    // Every lookup fails: 4 queries, 3 triggers, then an error.
    q0 = n_query; t0 = n_trig;
    sb.push_back({1'b1, 48'h0});
    do_req(32'hC0A8_0003, 1'b0);
    for (int i = 0; i < 3; i++) begin
      query_hs(32'hC0A8_0003);
      respond(48'hFFFF_FFFF_FFFF, 1'b1, 1'b0);
      trig_hs(32'hC0A8_0003);
    end
    query_hs(32'hC0A8_0003);
    respond(48'hFFFF_FFFF_FFFF, 1'b1, 1'b0);
    result("exhaust");
    check("exhaust_queries", 64'(n_query - q0), 64'd4);
    check("exhaust_trigs", 64'(n_trig - t0), 64'd3);

    // Timeout after 16 cycles, then a response on the timeout cycle wins.
    t0 = n_trig;
    sb.push_back({1'b0, 48'h0A0B_0C0D_0E0F});
    do_req(32'hC0A8_0004, 1'b0);
    query_hs(32'hC0A8_0004);
    cnt = 0;
    while (!trig_arp_qvalid_out && cnt < 100) begin @(negedge clk); cnt++; end
    check("timeout_len", 64'(cnt), 64'd16);
    trig_hs(32'hC0A8_0004);
    query_hs(32'hC0A8_0004);
    repeat (15) @(negedge clk);
    respond(48'h0A0B_0C0D_0E0F, 1'b0, 1'b0);
    result("edge_resp");
    check("timeout_trigs", 64'(n_trig - t0), 64'd1);

    // Flush with a same-IP request forces the lookup path.
    sb.push_back({1'b0, 48'h1111_2222_3333});
    do_req(32'hC0A8_0004, 1'b1);
    check("flush_req_miss", 64'({arp_query_valid_out, dst_mac_valid_out}), 64'b10);
    query_hs(32'hC0A8_0004);
    respond(48'h1111_2222_3333, 1'b0, 1'b0);
    result("flush_req");

    // Flush on the load cycle: result still returned, entry stays invalid.
    sb.push_back({1'b0, 48'h5555_6666_7777});
    do_req(32'hC0A8_0005, 1'b0);
    query_hs(32'hC0A8_0005);
    respond(48'h5555_6666_7777, 1'b0, 1'b1);
    result("flush_load");
    sb.push_back({1'b0, 48'h8888_9999_AAAA});
    do_req(32'hC0A8_0005, 1'b0);
    check("flush_load_miss", 64'({arp_query_valid_out, dst_mac_valid_out}), 64'b10);
    query_hs(32'hC0A8_0005);
    respond(48'h8888_9999_AAAA, 1'b0, 1'b0);
    result("relearn");

    // Reset during back-off aborts silently and invalidates the cache.
    do_req(32'hC0A8_0006, 1'b0);
    query_hs(32'hC0A8_0006);
    respond(48'h0, 1'b1, 1'b0);
    trig_hs(32'hC0A8_0006);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ctl", 64'({dst_req_ready_out, dst_err_out, dst_mac_valid_out, arp_query_valid_out,
                              arp_response_ready_out, trig_arp_qvalid_out}), 64'd0);
    check("mid_rst_data", 64'({dst_mac_out, arp_query_ip_out[15:0]}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", 64'({dst_req_ready_out, dst_mac_valid_out}), 64'b10);
    sb.push_back({1'b0, 48'hBEEF_0000_CAFE});
    do_req(32'hC0A8_0005, 1'b0);
    check("post_rst_miss", 64'({arp_query_valid_out, dst_mac_valid_out}), 64'b10);
    query_hs(32'hC0A8_0005);
    respond(48'hBEEF_0000_CAFE, 1'b0, 1'b0);
    result("post_rst");
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
